// File: rtl/sti_rx.sv
// sti_rx: serial-to-parallel receiver for 8/16/24/32-bit frames with 16-bit payload extraction.
module sti_rx (
  input  logic        clk,
  input  logic        reset,
  input  logic        si_data,
  input  logic        si_valid,
  input  logic [1:0]  cfg_length,
  input  logic        cfg_fill,
  input  logic        cfg_msb,
  input  logic        cfg_low,
  output logic [15:0] po_data,
  output logic        po_valid,
  output logic        po_pad_err,
  output logic        po_err,
  output logic        busy,
  output logic [13:0] frame_cnt
);
  typedef enum logic {IDLE, RECV} state_t;
  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] sr_q, sr_d, frame;
  logic [1:0]  len_q, len_d;
  logic        fill_q, fill_d, msb_q, msb_d, low_q, low_d;
  logic [15:0] data_q, data_d, ext;
  logic        valid_q, valid_d, pad_q, pad_d, err_q, err_d, pad;
  logic [13:0] fcnt_q, fcnt_d;
  // MSB-first frames shift in from the bottom; LSB-first frames place each bit at its arrival index
  always_comb begin
    frame = msb_q ? {sr_q[30:0], si_data} : (sr_q | (32'(si_data) << cnt_q[4:0]));
    ext = (len_q == 2'd0) ? (low_q ? {frame[7:0], 8'h00} : {8'h00, frame[7:0]}) :
          (len_q == 2'd2 && fill_q) ? frame[23:8] :
          (len_q == 2'd3 && fill_q) ? frame[31:16] : frame[15:0];
    pad = (len_q == 2'd2) ? (fill_q ? |frame[7:0] : |frame[23:16]) :
          (len_q == 2'd3) ? (fill_q ? |frame[15:0] : |frame[31:16]) : 1'b0;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    len_d   = len_q;
    fill_d  = fill_q;
    msb_d   = msb_q;
    low_d   = low_q;
    data_d  = data_q;
    fcnt_d  = fcnt_q;
    valid_d = 1'b0;
    pad_d   = 1'b0;
    err_d   = 1'b0;
    if (state_q == IDLE) begin
      if (si_valid) begin
        state_d = RECV;
        cnt_d   = 6'd1;
        sr_d    = {31'b0, si_data};
        len_d   = cfg_length;
        fill_d  = cfg_fill;
        msb_d   = cfg_msb;
        low_d   = cfg_low;
      end
    end else if (si_valid) begin
      cnt_d = cnt_q + 6'd1;
      sr_d  = frame;
      if (cnt_d == {1'b0, len_q, 3'b111} + 6'd1) begin
        state_d = IDLE;
        cnt_d   = 6'd0;
        valid_d = 1'b1;
        pad_d   = pad;
        data_d  = ext;
        fcnt_d  = fcnt_q + 14'd1;
      end
    end else begin
      state_d = IDLE;
      cnt_d   = 6'd0;
      err_d   = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      len_q   <= '0;
      fill_q  <= 1'b0;
      msb_q   <= 1'b0;
      low_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      pad_q   <= 1'b0;
      err_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      msb_q   <= msb_d;
      low_q   <= low_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      pad_q   <= pad_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
    end
  end
  assign po_data    = data_q;
  assign po_valid   = valid_q;
  assign po_pad_err = pad_q;
  assign po_err     = err_q;
  assign busy       = (state_q == RECV);
  assign frame_cnt  = fcnt_q;
endmodule
